// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
// Imported by the detector top and its counter.
package seq_det_pkg;

  typedef enum logic {
    UNARMED,
    ARMED
  } state_t;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_CNT_W   = 8;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over a simultaneous increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-configurable serial bit-pattern detector.
// Mealy match pulse, registered copy and saturating match count.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      x_valid,
  input  logic                      x,
  input  logic                      cfg_we,
  input  logic [MAX_LEN-1:0]        cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0] cfg_len,
  input  logic                      cfg_overlap,
  input  logic                      count_clr,
  output logic                      armed,
  output logic                      cfg_err,
  output logic                      match,
  output logic                      match_q,
  output logic [CNT_W-1:0]          match_count
);

  localparam int LEN_W = len_w(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);

  state_t             state;
  state_t             state_d;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic               overlap;
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] hit;
  logic               hit_all;
  logic               full;
  logic               cfg_ok;
  logic               cfg_bad;
  logic               accept;

  assign win = {hist, x};

  // Bits at or above len always compare equal.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign hit[i] = !(LEN_W'(i) < len)
                  | (win[i] == pattern[i]);
  end

  assign hit_all = &hit;
  assign full    = ({1'b0, fill} + 1'b1) >= {1'b0, len};
  assign cfg_ok  = (cfg_len >= LEN_MIN)
                && (cfg_len <= LEN_MAX);
  assign armed   = (state == ARMED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= UNARMED;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    match   = 1'b0;
    cfg_bad = 1'b0;
    unique case (1'b1)
      cfg_we: begin
        cfg_bad = !cfg_ok;
        if (cfg_ok) state_d = ARMED;
      end
      (!cfg_we && state == ARMED && x_valid): begin
        accept = 1'b1;
        match  = full && hit_all;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= '0;
      len     <= '0;
      overlap <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      cfg_err <= 1'b0;
      match_q <= 1'b0;
    end else begin
      cfg_err <= cfg_bad;
      match_q <= match;
      if (cfg_we && cfg_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
        hist    <= '0;
        fill    <= '0;
      end else if (accept) begin
        hist <= win[MAX_LEN-2:0];
        // Non-overlap: history must refill before the next match.
        if (match && !overlap) fill <= '0;
        else if (fill != LEN_MAX) fill <= fill + 1'b1;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (count_clr),
    .q     (match_count)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed scoreboard bench for seq_pattern_detector.
// Counter narrowed to 2 bits so saturation is reachable.
module tb_seq_pattern_detector;

  logic       clk;
  logic       reset;
  logic       x_valid;
  logic       x;
  logic       cfg_we;
  logic [15:0] cfg_pattern;
  logic [4:0] cfg_len;
  logic       cfg_overlap;
  logic       count_clr;
  logic       armed;
  logic       cfg_err;
  logic       match;
  logic       match_q;
  logic [1:0] match_count;

  int checks;
  int errors;
  bit exp_q[$];

  seq_pattern_detector #(
    .MAX_LEN (16),
    .CNT_W   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x_valid     (x_valid),
    .x           (x),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .armed       (armed),
    .cfg_err     (cfg_err),
    .match       (match),
    .match_q     (match_q),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock: drive, check Mealy output, then the registered copy.
  task automatic cyc(input bit v, input bit b,
                     input bit we, input bit clr,
                     input bit exp_m, input string tag);
    bit e;
    x_valid   = v;
    x         = b;
    cfg_we    = we;
    count_clr = clr;
    #1;
    chk({tag, " match"}, match, exp_m);
    exp_q.push_back(exp_m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " match_q"}, match_q, e);
    x_valid   = 1'b0;
    x         = 1'b0;
    cfg_we    = 1'b0;
    count_clr = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] p, input logic [4:0] l,
                     input bit ov, input string tag);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tag);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    x_valid     = 1'b0;
    x           = 1'b0;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    count_clr   = 1'b0;
    #1;
    chk("rst armed", armed, 0);
    chk("rst cfg_err", cfg_err, 0);
    chk("rst match", match, 0);
    chk("rst match_q", match_q, 0);
    chk("rst count", match_count, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Non-overlapping 11100
    cfg(16'b11100, 5'd5, 1'b0, "t1 cfg");
    chk("t1 armed", armed, 1);
    chk("t1 cfg_err", cfg_err, 0);
    cyc(1, 1, 0, 0, 0, "t1 b1");
    cyc(1, 1, 0, 0, 0, "t1 b2");
    cyc(1, 1, 0, 0, 0, "t1 b3");
    cyc(1, 1, 0, 0, 0, "t1 b4");
    cyc(1, 0, 0, 0, 0, "t1 b5");
    cyc(1, 0, 0, 0, 1, "t1 b6");
    chk("t1 count", match_count, 1);
    cyc(0, 0, 0, 1, 0, "t1 clr");
    chk("t1 count clr", match_count, 0);

    // 101 overlapping
    cfg(16'b101, 5'd3, 1'b1, "t2o cfg");
    cyc(1, 1, 0, 0, 0, "t2o b1");
    cyc(1, 0, 0, 0, 0, "t2o b2");
    cyc(1, 1, 0, 0, 1, "t2o b3");
    cyc(1, 0, 0, 0, 0, "t2o b4");
    cyc(1, 1, 0, 0, 1, "t2o b5");
    chk("t2o count", match_count, 2);
    cyc(0, 0, 0, 1, 0, "t2o clr");

    // 101 non-overlapping
    cfg(16'b101, 5'd3, 1'b0, "t2n cfg");
    cyc(1, 1, 0, 0, 0, "t2n b1");
    cyc(1, 0, 0, 0, 0, "t2n b2");
    cyc(1, 1, 0, 0, 1, "t2n b3");
    cyc(1, 0, 0, 0, 0, "t2n b4");
    cyc(1, 1, 0, 0, 0, "t2n b5");
    chk("t2n count", match_count, 1);
    cyc(0, 0, 0, 1, 0, "t2n clr");

    // Valid gaps
    cfg(16'b11, 5'd2, 1'b1, "t3 cfg");
    cyc(1, 1, 0, 0, 0, "t3 b1");
    cyc(0, 1, 0, 0, 0, "t3 gap1");
    cyc(0, 1, 0, 0, 0, "t3 gap2");
    cyc(0, 1, 0, 0, 0, "t3 gap3");
    cyc(1, 1, 0, 0, 1, "t3 b2");
    chk("t3 count", match_count, 1);

    // cfg_we with a data bit: bit dropped, fill cleared
    cfg_pattern = 16'b01;
    cfg_len     = 5'd2;
    cfg_overlap = 1'b1;
    cyc(1, 1, 1, 0, 0, "t3 prio");
    chk("t3 prio err", cfg_err, 0);
    cyc(1, 1, 0, 0, 0, "t3 refill1");
    cyc(1, 0, 0, 0, 0, "t3 refill2");
    cyc(1, 1, 0, 0, 1, "t3 refill3");
    chk("t3 count2", match_count, 2);
    cyc(0, 0, 0, 1, 0, "t3 clr");

    // Saturation, fill saturation, clear priority
    cfg(16'b11, 5'd2, 1'b1, "t4 cfg");
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 0, 0, (i > 0), "t4 ones");
      if (i == 2) chk("t4 count mid", match_count, 2);
    end
    chk("t4 count sat", match_count, 3);
    cyc(1, 1, 0, 1, 1, "t4 clr+match");
    chk("t4 count clr", match_count, 0);

    // Illegal length while armed keeps old config
    cfg(16'h0, 5'd17, 1'b0, "t4 bad cfg");
    chk("t4 bad err", cfg_err, 1);
    chk("t4 bad armed", armed, 1);
    cyc(1, 1, 0, 0, 1, "t4 old pat");
    chk("t4 err drop", cfg_err, 0);
    chk("t4 count1", match_count, 1);

    // Asynchronous reset mid-pattern
    cfg(16'b11100, 5'd5, 1'b0, "t5 cfg");
    cyc(1, 1, 0, 0, 0, "t5 b1");
    cyc(1, 1, 0, 0, 0, "t5 b2");
    cyc(1, 1, 0, 0, 0, "t5 b3");
    #3;
    reset = 1'b1;
    #1;
    chk("t5 armed", armed, 0);
    chk("t5 count", match_count, 0);
    chk("t5 match_q", match_q, 0);
    chk("t5 cfg_err", cfg_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1, 0, 0, 0, 0, "t5 b4");
    cyc(1, 0, 0, 0, 0, "t5 b5");
    chk("t5 armed after", armed, 0);
    chk("t5 count after", match_count, 0);

    // Illegal length while unarmed
    cfg(16'b1, 5'd1, 1'b0, "t6 cfg");
    chk("t6 err", cfg_err, 1);
    chk("t6 armed", armed, 0);
    cyc(0, 0, 0, 0, 0, "t6 idle");
    chk("t6 err drop", cfg_err, 0);
    chk("t6 armed2", armed, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial bit-pattern detector, successor to the fixed five-bit "11100" Mealy detector. Pattern, pattern length and overlap mode are runtime-configurable up to `MAX_LEN` bits. The block provides a combinational Mealy match pulse, a registered copy and a saturating match counter. It sits on a single-bit serial input stream, qualified by a valid strobe, in the lab datapath.

## Interface
Parameters:
- `MAX_LEN`, default 16: maximum pattern length in bits, ≥ 2.
- `CNT_W`, default 8: width of the match counter.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `x_valid` in 1: qualifies `x`; a bit is consumed only when `x_valid` = 1.
- `x` in 1: serial data bit.
- `cfg_we` in 1: configuration write strobe.
- `cfg_pattern` in `MAX_LEN`: pattern. `cfg_pattern[len-1]` is the oldest (first-received) bit and `cfg_pattern[0]` is the newest; bits at and above `len` are ignored.
- `cfg_len` in `LEN_W` = `$clog2(MAX_LEN+1)`: pattern length.
- `cfg_overlap` in 1: 1 = overlapping detection, 0 = non-overlapping.
- `count_clr` in 1: synchronous clear of `match_count`.
- `armed` out 1: a valid configuration is loaded.
- `cfg_err` out 1: one-cycle pulse when a configuration write is rejected.
- `match` out 1: Mealy (combinational) match for the bit currently presented.
- `match_q` out 1: `match` registered.
- `match_count` out `CNT_W`: saturating count of matches.

## Operation
- State machine has two states.
  - `UNARMED`: entered on reset. Bits are ignored and `match` = 0.
  - `ARMED`: detection active.
- Configuration write, when `cfg_we` = 1:
  - Legal configuration is 2 ≤ `cfg_len` ≤ `MAX_LEN`.
  - Legal: latch pattern, length and overlap mode; clear `hist` and `fill`; go to `ARMED`.
  - Illegal: pulse `cfg_err` the next cycle; configuration and state are unchanged.
  - `cfg_we` has priority over a simultaneous `x_valid`: that data bit is discarded and `match` = 0 that cycle.
- Registers:
  - `hist[MAX_LEN-2:0]` holds the previously accepted bits.
  - `fill` counts accepted bits since the last clear, saturating at `MAX_LEN`.
- Match condition: `match` = `ARMED` & `x_valid` & !`cfg_we` & (`fill` + 1 ≥ `len`) & (the low `len` bits of {`hist`, `x`} equal the low `len` bits of `pattern`).
- Update on an accepted bit:
  - `hist` ← {`hist`, `x`}.
  - `fill` ← sat(`fill` + 1).
  - Exception: on a non-overlapping match, `fill` ← 0. `hist` still shifts but is unusable until `fill` refills.
- `match_count`:
  - Increments on each `match` and saturates at 2^`CNT_W` − 1.
  - `count_clr` wins over a simultaneous match: the result is 0.
  - A configuration write does not clear the counter.

## Timing
- Reset values: state `UNARMED`; `pattern`, `len`, `overlap`, `hist`, `fill` = 0; all outputs 0.
- `match`: zero latency. It is valid in the same cycle as the completing bit and depends combinationally on `x`, `x_valid` and `cfg_we`.
- `match_q`, `match_count` and `cfg_err`: update on the clock edge after the event.
- `armed` rises on the clock edge after a legal `cfg_we`. The earliest possible match is on the `len`-th accepted bit after that edge.
- Gaps in `x_valid` do not break a pattern; only accepted bits count.
- Reset mid-stream: asynchronous; it clears everything, including the configuration, and a reconfiguration is required before detection resumes.
- `fill` saturation at `MAX_LEN` must not suppress subsequent overlapping matches.

## Structure
- Shared package `seq_det_pkg` holds:
  - the state enum `{UNARMED, ARMED}`;
  - default `MAX_LEN` and `CNT_W`;
  - a function returning `LEN_W`.
- One sub-module, `sat_counter` (parameter `W`; ports `inc`, `clr`, `q`), implements `match_count`.
- Length-masked compare: a generate loop over `MAX_LEN` with a per-bit enable of (bit index < `len`).

## Test plan
- Non-overlap baseline: configure `cfg_pattern` = 5'b11100, `len` = 5, `cfg_overlap` = 0; stream 1,1,1,1,0,0 → `match` high only on the 6th bit; `match_q` one cycle later; `match_count` = 1.
- Overlap vs non-overlap: pattern 3'b101, `len` = 3; stream 1,0,1,0,1 → overlap mode matches on bits 3 and 5 (`match_count` = 2); non-overlap mode matches on bit 3 only (`match_count` = 1).
- Valid gaps and priority:
  - Pattern 11, with `x_valid` low for 3 cycles between the two 1s → match on the second 1.
  - `cfg_we` issued together with the completing bit → no match; `fill` = 0.
- Illegal configuration:
  - `cfg_len` = 1 → `cfg_err` pulses once; `armed` stays 0.
  - `cfg_len` = `MAX_LEN` + 1 while armed → `cfg_err` pulses; the old pattern still matches.
- Saturation and clear: `CNT_W` = 2, overlap, pattern 11, seven 1s → 6 matches; count sticks at 3. `count_clr` together with a match → count = 0.
- Reset mid-pattern: after 1,1,1 of 11100, assert `reset` asynchronously → all outputs 0 and `armed` = 0; bits 0,0 then produce no match.
